// File: rtl/dla_tile_sequencer_if.sv
// Sequencer bus bundle: IFM ping-pong buffer handshake,
// PE window coordinates and delayed psum write strobes.
interface dla_tile_sequencer_if #(
    parameter int DIM_BITS      = 7,
    parameter int OUT_ADDR_BITS = 14
);
    logic [1:0]               buf_full_set;
    logic [1:0]               buf_full;
    logic [1:0]               buf_release;
    logic                     buf_sel;
    logic                     win_valid;
    logic [DIM_BITS-1:0]      win_x0;
    logic [DIM_BITS-1:0]      win_y0;
    logic                     out_w_en;
    logic [OUT_ADDR_BITS-1:0] out_addr;
    logic                     first_channel;
    logic                     last_channel;

    modport master (
        input  buf_full_set,
        output buf_full,
        output buf_release,
        output buf_sel,
        output win_valid,
        output win_x0,
        output win_y0,
        output out_w_en,
        output out_addr,
        output first_channel,
        output last_channel
    );

    modport slave (
        output buf_full_set,
        input  buf_full,
        input  buf_release,
        input  buf_sel,
        input  win_valid,
        input  win_x0,
        input  win_y0,
        input  out_w_en,
        input  out_addr,
        input  first_channel,
        input  last_channel
    );
endinterface

// File: rtl/dla_tile_sequencer.sv
// DLA tile sequencer: walks the output map per input channel,
// drives ping-pong IFM buffers and delayed psum write strobes.
module dla_tile_sequencer #(
    parameter int DIM_BITS      = 7,
    parameter int CH_BITS       = 10,
    parameter int PIPE_LAT      = 3,
    parameter int OUT_ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIM_BITS-1:0]  cfg_in_w,
    input  logic [DIM_BITS-1:0]  cfg_in_h,
    input  logic [CH_BITS-1:0]   cfg_channels,
    input  logic                 cfg_ksize,
    input  logic                 cfg_stride,
    input  logic                 stall,
    input  logic                 irq_clr,
    dla_tile_sequencer_if.master bus,
    output logic                 busy,
    output logic                 err,
    output logic                 done_irq
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUF,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic                     valid;
        logic [OUT_ADDR_BITS-1:0] addr;
        logic                     first;
        logic                     last;
    } dl_ent_t;

    state_t                   state;
    logic [DIM_BITS-1:0]      ox;
    logic [DIM_BITS-1:0]      oy;
    logic [DIM_BITS-1:0]      ow_m1;
    logic [DIM_BITS-1:0]      oh_m1;
    logic [CH_BITS-1:0]       ch_cnt;
    logic [CH_BITS-1:0]       ch_last;
    logic                     stride_q;
    logic                     cur_buf;
    logic [1:0]               full_q;
    logic [OUT_ADDR_BITS-1:0] pix;
    dl_ent_t                  dl [PIPE_LAT];

    logic [DIM_BITS-1:0]      kdim;
    logic                     cfg_ok;
    logic                     go;
    logic                     run;
    logic                     dl_empty;
    logic                     rel;
    logic [1:0]               rel_vec;

    assign kdim    = cfg_ksize ? DIM_BITS'(3) : DIM_BITS'(1);
    assign cfg_ok  = (cfg_in_w >= kdim) && (cfg_in_h >= kdim) &&
                     (cfg_channels != '0);
    assign go      = !stall;
    assign run     = (state == RUN) && go;
    assign rel     = (state == DRAIN) && go && dl_empty;
    assign rel_vec = rel ? (cur_buf ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        dl_empty = 1'b1;
        for (int i = 0; i < PIPE_LAT; i++)
            if (dl[i].valid) dl_empty = 1'b0;
    end

    assign bus.buf_full      = full_q;
    assign bus.buf_release   = rel_vec;
    assign bus.buf_sel       = cur_buf;
    assign bus.win_valid     = run;
    assign bus.win_x0        = ox << stride_q;
    assign bus.win_y0        = oy << stride_q;
    assign bus.out_w_en      = dl[PIPE_LAT-1].valid && go;
    assign bus.out_addr      = dl[PIPE_LAT-1].addr;
    assign bus.first_channel = dl[PIPE_LAT-1].first;
    assign bus.last_channel  = dl[PIPE_LAT-1].last;
    assign busy              = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ox       <= '0;
            oy       <= '0;
            ow_m1    <= '0;
            oh_m1    <= '0;
            ch_cnt   <= '0;
            ch_last  <= '0;
            stride_q <= 1'b0;
            cur_buf  <= 1'b0;
            full_q   <= '0;
            pix      <= '0;
            err      <= 1'b0;
            done_irq <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++)
                dl[i] <= '0;
        end else begin
            // host set beats our own release in the same cycle
            full_q <= (full_q & ~rel_vec) | bus.buf_full_set;
            if (irq_clr) begin
                err      <= 1'b0;
                done_irq <= 1'b0;
            end
            if (go) begin
                dl[0] <= '{valid: run,
                           addr:  pix,
                           first: (ch_cnt == '0),
                           last:  (ch_cnt == ch_last)};
                for (int i = 1; i < PIPE_LAT; i++)
                    dl[i] <= dl[i-1];
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            ow_m1    <= (cfg_in_w - kdim) >> cfg_stride;
                            oh_m1    <= (cfg_in_h - kdim) >> cfg_stride;
                            ch_last  <= cfg_channels - 1'b1;
                            stride_q <= cfg_stride;
                            ch_cnt   <= '0;
                            state    <= WAIT_BUF;
                        end else begin
                            err      <= 1'b1;
                            done_irq <= 1'b1;
                        end
                    end
                end
                WAIT_BUF: begin
                    if (go && full_q[cur_buf]) begin
                        ox    <= '0;
                        oy    <= '0;
                        pix   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (go) begin
                        // raster order makes the pixel index oy*out_w+ox
                        pix <= pix + 1'b1;
                        if (ox == ow_m1) begin
                            ox <= '0;
                            if (oy == oh_m1) state <= DRAIN;
                            else             oy    <= oy + 1'b1;
                        end else begin
                            ox <= ox + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (rel) begin
                        if (ch_cnt == ch_last) begin
                            state <= DONE;
                        end else begin
                            ch_cnt  <= ch_cnt + 1'b1;
                            cur_buf <= ~cur_buf;
                            state   <= WAIT_BUF;
                        end
                    end
                end
                DONE: begin
                    if (go) begin
                        done_irq <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dla_tile_sequencer.sv
// Bench for dla_tile_sequencer: directed layers plus random
// layers scored against a queue-based reference model.
module tb_dla_tile_sequencer;
    localparam int DB = 7;
    localparam int CB = 10;
    localparam int PL = 3;
    localparam int AB = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ksize = 1'b0;
    logic          stride = 1'b0;
    logic          stall = 1'b0;
    logic          irq_clr = 1'b0;
    logic [DB-1:0] in_w = '0;
    logic [DB-1:0] in_h = '0;
    logic [CB-1:0] chs = '0;
    logic          busy;
    logic          err;
    logic          done_irq;

    dla_tile_sequencer_if #(.DIM_BITS(DB), .OUT_ADDR_BITS(AB)) bus ();

    dla_tile_sequencer #(
        .DIM_BITS(DB), .CH_BITS(CB), .PIPE_LAT(PL), .OUT_ADDR_BITS(AB)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_in_w(in_w), .cfg_in_h(in_h), .cfg_channels(chs),
        .cfg_ksize(ksize), .cfg_stride(stride),
        .stall(stall), .irq_clr(irq_clr), .bus(bus),
        .busy(busy), .err(err), .done_irq(done_irq)
    );

    typedef struct {
        int x0; int y0; int addr;
        bit f; bit l; bit eoc; bit b;
    } win_t;
    typedef struct {
        int due; int addr; bit f; bit l;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    win_t wq[$];
    wr_t  rq[$];
    int   ns = 0;
    int   win_cnt = 0;
    int   rel_due = 0;
    int   rel_cnt = 0;
    bit [1:0] mfull;
    bit   mbuf, mdone, merr, mbusy, in_run;
    bit   rel_pend, rel_b, rel_final, done_arm;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        wq.delete();
        rq.delete();
        mfull = 2'b00; mbuf = 1'b0; mdone = 1'b0; merr = 1'b0;
        mbusy = 1'b0; in_run = 1'b0; rel_pend = 1'b0;
        done_arm = 1'b0; rel_final = 1'b0; rel_b = 1'b0;
    endfunction

    // expected windows of a whole layer, straight from the size rules
    function automatic void build();
        int k, ow, oh;
        bit b;
        win_t w;
        k  = ksize ? 3 : 1;
        ow = ((int'(in_w) - k) >> stride) + 1;
        oh = ((int'(in_h) - k) >> stride) + 1;
        b  = mbuf;
        for (int c = 0; c < int'(chs); c++) begin
            for (int y = 0; y < oh; y++)
                for (int x = 0; x < ow; x++) begin
                    w.x0 = x << stride;  w.y0 = y << stride;
                    w.addr = y * ow + x;
                    w.f = (c == 0);      w.l = (c == int'(chs) - 1);
                    w.eoc = (x == ow - 1) && (y == oh - 1);
                    w.b = b;
                    wq.push_back(w);
                end
            if (c != int'(chs) - 1) b = ~b;
        end
        mbuf = b;
        rel_cnt = 0;
    endfunction

    task automatic step(input bit r, input bit st, input bit sl,
                        input bit [1:0] set, input bit clr);
        bit [1:0] exp_rel;
        bit exp_we, set_done, set_err, busy_n, valid_cfg;
        win_t w;
        wr_t e;
        @(posedge clk);
        #1;
        rst = r; start = st; stall = sl;
        bus.buf_full_set = set; irq_clr = clr;
        if (!st) begin
            in_w = DB'($urandom_range(0, 127));
            in_h = DB'($urandom_range(0, 127));
            chs = CB'($urandom_range(0, 1023));
            ksize = 1'($urandom_range(0, 1));
            stride = 1'($urandom_range(0, 1));
        end
        #3;
        if (r) begin
            model_reset();
            return;
        end
        chk("busy", 32'(busy), 32'(mbusy));
        chk("done_irq", 32'(done_irq), 32'(mdone));
        chk("err", 32'(err), 32'(merr));
        chk("buf_full", 32'(bus.buf_full), 32'(mfull));
        if (sl) chk("win_valid_stall", 32'(bus.win_valid), 0);
        else if (in_run) chk("win_valid_run", 32'(bus.win_valid), 1);
        if (bus.win_valid === 1'b1) begin
            if (wq.size() == 0) begin
                chk("win_extra", 32'(bus.win_valid), 0);
            end else begin
                w = wq.pop_front();
                win_cnt++;
                chk("win_x0", 32'(bus.win_x0), w.x0);
                chk("win_y0", 32'(bus.win_y0), w.y0);
                chk("buf_sel", 32'(bus.buf_sel), 32'(w.b));
                chk("win_buf_full", 32'(bus.buf_full[bus.buf_sel]), 1);
                rq.push_back('{due: ns + PL, addr: w.addr, f: w.f, l: w.l});
                in_run = !w.eoc;
                if (w.eoc) begin
                    rel_pend = 1'b1; rel_due = ns + PL + 1;
                    rel_b = w.b; rel_final = (wq.size() == 0);
                end
            end
        end
        exp_we = !sl && rq.size() > 0 && rq[0].due == ns;
        chk("out_w_en", 32'(bus.out_w_en), 32'(exp_we));
        if (exp_we) begin
            e = rq.pop_front();
            chk("out_addr", 32'(bus.out_addr), e.addr);
            chk("first_channel", 32'(bus.first_channel), 32'(e.f));
            chk("last_channel", 32'(bus.last_channel), 32'(e.l));
        end
        exp_rel = (!sl && rel_pend && ns == rel_due) ?
                  (rel_b ? 2'b10 : 2'b01) : 2'b00;
        chk("buf_release", 32'(bus.buf_release), 32'(exp_rel));
        set_done = 1'b0; set_err = 1'b0; busy_n = mbusy;
        if (done_arm && !sl) begin
            set_done = 1'b1; busy_n = 1'b0; done_arm = 1'b0;
        end
        if (exp_rel != 2'b00) begin
            rel_pend = 1'b0; rel_cnt++;
            if (rel_final) done_arm = 1'b1;
        end
        if (st && !mbusy) begin
            valid_cfg = (int'(in_w) >= (ksize ? 3 : 1)) &&
                        (int'(in_h) >= (ksize ? 3 : 1)) && (chs != 0);
            if (valid_cfg) begin
                busy_n = 1'b1;
                build();
            end else begin
                set_err = 1'b1; set_done = 1'b1;
            end
        end
        mdone = (mdone && !clr) || set_done;
        merr  = (merr && !clr) || set_err;
        mfull = (mfull & ~exp_rel) | set;
        mbusy = busy_n;
        if (!sl) ns++;
    endtask

    task automatic chk_zero();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_done_irq", 32'(done_irq), 0);
        chk("rst_buf_full", 32'(bus.buf_full), 0);
        chk("rst_buf_release", 32'(bus.buf_release), 0);
        chk("rst_buf_sel", 32'(bus.buf_sel), 0);
        chk("rst_win_valid", 32'(bus.win_valid), 0);
        chk("rst_win_x0", 32'(bus.win_x0), 0);
        chk("rst_win_y0", 32'(bus.win_y0), 0);
        chk("rst_out_w_en", 32'(bus.out_w_en), 0);
        chk("rst_out_addr", 32'(bus.out_addr), 0);
        chk("rst_first", 32'(bus.first_channel), 0);
        chk("rst_last", 32'(bus.last_channel), 0);
    endtask

    // smode: 0 no stall, 1 random stall/irq_clr/junk, 2 two-cycle stalls
    task automatic run_layer(input int w, input int h, input int c,
                             input bit k, input bit s, input int smode,
                             input int ch1_dly, input int abort_at);
        int win0, wait_cnt, rnd_dly, cur_dly, sc_run, sc_dr;
        bit st, sl, clr, junk_done;
        bit [1:0] set;
        in_w = DB'(w); in_h = DB'(h); chs = CB'(c);
        ksize = k; stride = s;
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        win0 = win_cnt; wait_cnt = 0; rnd_dly = $urandom_range(0, 4);
        sc_run = 0; sc_dr = 0; junk_done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (!mbusy && wq.size() == 0 && rq.size() == 0 &&
                !rel_pend && !done_arm) break;
            if (abort_at >= 0 && win_cnt - win0 == abort_at) begin
                step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
                step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
                chk_zero();
                return;
            end
            st = 1'b0; sl = 1'b0; clr = 1'b0; set = 2'b00;
            cur_dly = (ch1_dly >= 0) ? ((rel_cnt == 1) ? ch1_dly : 0)
                                     : rnd_dly;
            if (!in_run && wq.size() > 0 && !rel_pend && mbusy &&
                !mfull[wq[0].b]) begin
                if (wait_cnt >= cur_dly) begin
                    set[wq[0].b] = 1'b1;
                    wait_cnt = 0;
                    rnd_dly = $urandom_range(0, 4);
                end else begin
                    wait_cnt++;
                end
            end
            if (smode == 1) begin
                sl = ($urandom_range(0, 5) == 0);
                clr = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 15) == 0)
                    set[$urandom_range(0, 1)] = 1'b1;
                if (!junk_done && win_cnt - win0 == 1) begin
                    st = 1'b1; junk_done = 1'b1;
                end
            end else if (smode == 2) begin
                if (in_run && win_cnt - win0 >= 2 && sc_run < 2) begin
                    sl = 1'b1; sc_run++;
                end
                if (rel_pend && sc_dr < 2) begin
                    sl = 1'b1; sc_dr++;
                end
            end
            step(1'b0, st, sl, set, clr);
        end
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("layer_drained", wq.size() + rq.size(), 0);
        chk("layer_idle", 32'(busy), 0);
    endtask

    task automatic clear_irq();
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        bus.buf_full_set = 2'b00;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk_zero();

        run_layer(4, 4, 1, 1'b1, 1'b0, 0, -1, -1);
        clear_irq();
        run_layer(7, 7, 1, 1'b1, 1'b1, 0, -1, -1);
        clear_irq();
        run_layer(3, 3, 3, 1'b0, 1'b0, 0, 10, -1);
        clear_irq();
        run_layer(5, 5, 2, 1'b1, 1'b0, 2, -1, -1);
        clear_irq();

        in_w = 7'd2; in_h = 7'd5; chs = 10'd1; ksize = 1'b1; stride = 1'b0;
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        clear_irq();
        in_w = 7'd5; in_h = 7'd5; chs = 10'd0; ksize = 1'b0;
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        clear_irq();

        run_layer(6, 6, 2, 1'b0, 1'b0, 0, -1, 3);
        run_layer(6, 6, 2, 1'b0, 1'b0, 0, -1, -1);
        clear_irq();

        for (int n = 0; n < 12; n++) begin
            bit kr, sr;
            int kk;
            kr = 1'($urandom_range(0, 1));
            sr = 1'($urandom_range(0, 1));
            kk = kr ? 3 : 1;
            run_layer(kk + $urandom_range(0, 6), kk + $urandom_range(0, 6),
                      $urandom_range(1, 3), kr, sr, 1, -1, -1);
            clear_irq();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
